// File: rtl/decode_stage.sv
// Decode stage: field decode, register file with writeback bypass, per-register in-flight
// writer scoreboard, dependency/branch stall generation and the registered DE/EX latch.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned SB_MAX     = 3
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET,
  input  logic                  I_LOCK,
  input  logic [15:0]           I_PC,
  input  logic [31:0]           I_IR,
  input  logic                  I_FetchStall,
  input  logic                  I_FRAMESTALL,
  input  logic                  I_BranchAddrSelect,
  input  logic                  I_WBEnable,
  input  logic [3:0]            I_WBRegIdx,
  input  logic [DATA_WIDTH-1:0] I_WBData,
  output logic                  O_LOCK,
  output logic [15:0]           O_PC,
  output logic [7:0]            O_Opcode,
  output logic [3:0]            O_DestRegIdx,
  output logic [DATA_WIDTH-1:0] O_Src1Value,
  output logic [DATA_WIDTH-1:0] O_Src2Value,
  output logic                  O_DEStall,
  output logic                  O_DepStallSignal,
  output logic                  O_BranchStallSignal
);

  localparam logic [7:0] OpNop  = 8'hFF;
  localparam logic [1:0] SbMax  = SB_MAX[1:0];

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
  logic [1:0]            sb_q [NUM_REGS];
  logic [1:0]            sb_d [NUM_REGS];

  logic                  lock_q, lock_d;
  logic [15:0]           pc_q, pc_d;
  logic [7:0]            op_q, op_d;
  logic [3:0]            dr_q, dr_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d;
  logic [DATA_WIDTH-1:0] src2_q, src2_d;
  logic                  destall_q, destall_d;
  logic                  bp_q, bp_d;

  logic [7:0]            opcode;
  logic [3:0]            dr, sr1, sr2;
  logic [15:0]           imm;
  logic                  is_nop, is_branch, is_imm;
  logic                  writes_dr, reads_sr1, reads_sr2;
  logic                  wb_hit1, wb_hit2;
  logic [1:0]            eff1, eff2;
  logic                  hazard, issue;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  assign opcode = I_IR[31:24];
  assign dr     = I_IR[23:20];
  assign sr1    = I_IR[19:16];
  assign sr2    = I_IR[11:8];
  assign imm    = I_IR[15:0];

  always_comb begin
    is_nop    = (opcode == OpNop);
    is_branch = !is_nop && (opcode[7:6] == 2'b10);
    is_imm    = !is_nop && (opcode[7:6] == 2'b01);
    writes_dr = !is_nop && !opcode[7];
    reads_sr1 = !is_nop && (!is_branch || opcode[5]);
    reads_sr2 = !is_nop && (opcode[7:6] == 2'b00 || opcode[7:6] == 2'b11);

    wb_hit1 = I_WBEnable && (I_WBRegIdx == sr1);
    wb_hit2 = I_WBEnable && (I_WBRegIdx == sr2);
    // A writeback landing this edge retires one in-flight writer early.
    eff1 = sb_q[sr1] - {1'b0, (wb_hit1 && sb_q[sr1] != 2'd0)};
    eff2 = sb_q[sr2] - {1'b0, (wb_hit2 && sb_q[sr2] != 2'd0)};

    hazard = (reads_sr1 && eff1 != 2'd0) || (reads_sr2 && eff2 != 2'd0) ||
             (writes_dr && sb_q[dr] == SbMax);

    issue = I_LOCK && !I_FRAMESTALL && !I_FetchStall && !hazard && !bp_q && !is_nop;

    rd1 = wb_hit1 ? I_WBData : rf_q[sr1];
    rd2 = wb_hit2 ? I_WBData : rf_q[sr2];
  end

  assign O_DepStallSignal = hazard && I_LOCK && !I_FetchStall && !bp_q;

  always_comb begin : sb_next
    logic inc, dec;
    rf_d = rf_q;
    if (I_WBEnable) rf_d[I_WBRegIdx] = I_WBData;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc     = issue && writes_dr && (dr == 4'(i));
      dec     = I_WBEnable && (I_WBRegIdx == 4'(i)) && (sb_q[i] != 2'd0);
      sb_d[i] = sb_q[i] + {1'b0, inc} - {1'b0, dec};
    end
  end

  always_comb begin
    lock_d    = I_LOCK;
    pc_d      = pc_q;
    op_d      = op_q;
    dr_d      = dr_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    destall_d = destall_q;
    bp_d      = bp_q;
    if (!I_FRAMESTALL) begin
      if (issue) begin
        pc_d      = I_PC;
        op_d      = opcode;
        dr_d      = dr;
        src1_d    = rd1;
        src2_d    = is_imm ? DATA_WIDTH'($signed(imm)) : rd2;
        destall_d = 1'b0;
      end else begin
        op_d      = OpNop;
        destall_d = 1'b1;
      end
      if (bp_q && I_BranchAddrSelect) bp_d = 1'b0;
      else if (issue && is_branch)    bp_d = 1'b1;
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
        sb_q[i] <= 2'd0;
      end
      lock_q    <= 1'b0;
      pc_q      <= '0;
      op_q      <= OpNop;
      dr_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      destall_q <= 1'b1;
      bp_q      <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      sb_q      <= sb_d;
      lock_q    <= lock_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      dr_q      <= dr_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      destall_q <= destall_d;
      bp_q      <= bp_d;
    end
  end

  assign O_LOCK              = lock_q;
  assign O_PC                = pc_q;
  assign O_Opcode            = op_q;
  assign O_DestRegIdx        = dr_q;
  assign O_Src1Value         = src1_q;
  assign O_Src2Value         = src2_q;
  assign O_DEStall           = destall_q;
  assign O_BranchStallSignal = bp_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage, plus a hand-written branch-pending sequence.
module tb_decode_stage;

  logic        I_CLOCK, I_RESET, I_LOCK, I_FetchStall, I_FRAMESTALL, I_BranchAddrSelect;
  logic        I_WBEnable;
  logic [3:0]  I_WBRegIdx;
  logic [15:0] I_WBData, I_PC;
  logic [31:0] I_IR;
  logic        O_LOCK, O_DEStall, O_DepStallSignal, O_BranchStallSignal;
  logic [15:0] O_PC, O_Src1Value, O_Src2Value;
  logic [7:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;

  decode_stage dut (
    .I_CLOCK            (I_CLOCK),
    .I_RESET            (I_RESET),
    .I_LOCK             (I_LOCK),
    .I_PC               (I_PC),
    .I_IR               (I_IR),
    .I_FetchStall       (I_FetchStall),
    .I_FRAMESTALL       (I_FRAMESTALL),
    .I_BranchAddrSelect (I_BranchAddrSelect),
    .I_WBEnable         (I_WBEnable),
    .I_WBRegIdx         (I_WBRegIdx),
    .I_WBData           (I_WBData),
    .O_LOCK             (O_LOCK),
    .O_PC               (O_PC),
    .O_Opcode           (O_Opcode),
    .O_DestRegIdx       (O_DestRegIdx),
    .O_Src1Value        (O_Src1Value),
    .O_Src2Value        (O_Src2Value),
    .O_DEStall          (O_DEStall),
    .O_DepStallSignal   (O_DepStallSignal),
    .O_BranchStallSignal(O_BranchStallSignal)
  );

  initial I_CLOCK = 1'b1;
  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    logic        rst, lock, fst, frz, bas, wbe;
    logic [3:0]  wbi;
    logic [15:0] wbd;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        e_dep, e_destall, e_bs, e_lock;
    logic [7:0]  e_op;
    logic [3:0]  e_dr;
    logic [15:0] e_pc, e_s1, e_s2;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic lock, input logic fst, input logic frz,
                       input logic bas, input logic wbe, input logic [3:0] wbi,
                       input logic [15:0] wbd, input logic [31:0] ir, input logic [15:0] pc);
    I_RESET = rst; I_LOCK = lock; I_FetchStall = fst; I_FRAMESTALL = frz;
    I_BranchAddrSelect = bas; I_WBEnable = wbe; I_WBRegIdx = wbi; I_WBData = wbd;
    I_IR = ir; I_PC = pc;
  endtask

  initial begin
    // rst lock fst frz bas wbe wbi wbd ir pc | dep destall bs lock op dr pc s1 s2
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'hFF000000,16'h0000,
                 1'b0,1'b1,1'b0,1'b0,8'hFF,4'h0,16'h0000,16'h0000,16'h0000};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h1,16'h1111,32'hFF000000,16'h0000,
                 1'b0,1'b1,1'b0,1'b1,8'hFF,4'h0,16'h0000,16'h0000,16'h0000};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h2,16'h2222,32'h01310200,16'h0004,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h3,16'h0004,16'h1111,16'h2222};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h4043FFF0,16'h0008,
                 1'b1,1'b1,1'b0,1'b1,8'hFF,4'h3,16'h0004,16'h1111,16'h2222};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h3,16'h00AB,32'h4043FFF0,16'h0008,
                 1'b0,1'b0,1'b0,1'b1,8'h40,4'h4,16'h0008,16'h00AB,16'hFFF0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01500000,16'h000C,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h5,16'h000C,16'h0000,16'h0000};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01500000,16'h0010,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h5,16'h0010,16'h0000,16'h0000};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01500000,16'h0014,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h5,16'h0014,16'h0000,16'h0000};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01500000,16'h0018,
                 1'b1,1'b1,1'b0,1'b1,8'hFF,4'h5,16'h0014,16'h0000,16'h0000};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h5,16'h5555,32'h01500000,16'h0018,
                 1'b1,1'b1,1'b0,1'b1,8'hFF,4'h5,16'h0014,16'h0000,16'h0000};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h5,16'h5556,32'h01500000,16'h001C,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h5,16'h001C,16'h0000,16'h0000};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h5,16'h7777,32'h40650001,16'h0020,
                 1'b1,1'b1,1'b0,1'b1,8'hFF,4'h5,16'h001C,16'h0000,16'h0000};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h5,16'h8888,32'h40650001,16'h0020,
                 1'b0,1'b0,1'b0,1'b1,8'h40,4'h6,16'h0020,16'h8888,16'h0001};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h80000000,16'h0024,
                 1'b0,1'b0,1'b1,1'b1,8'h80,4'h0,16'h0024,16'h0000,16'h0000};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01710200,16'h0028,
                 1'b0,1'b1,1'b1,1'b1,8'hFF,4'h0,16'h0024,16'h0000,16'h0000};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'h0,16'h0000,32'h01710200,16'h0028,
                 1'b0,1'b1,1'b0,1'b1,8'hFF,4'h0,16'h0024,16'h0000,16'h0000};
    vecs[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01710200,16'h0028,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h7,16'h0028,16'h1111,16'h2222};
    vecs[18] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,4'h8,16'h8080,32'h40980000,16'h002C,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h7,16'h0028,16'h1111,16'h2222};
    vecs[19] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'h0,16'h0000,32'h40980000,16'h002C,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h7,16'h0028,16'h1111,16'h2222};
    vecs[20] = vecs[19];
    vecs[21] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h40980000,16'h002C,
                 1'b0,1'b0,1'b0,1'b1,8'h40,4'h9,16'h002C,16'h8080,16'h0000};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h40A70000,16'h0030,
                 1'b0,1'b1,1'b0,1'b0,8'hFF,4'h9,16'h002C,16'h8080,16'h0000};
    vecs[23] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h40A70000,16'h0030,
                 1'b1,1'b1,1'b0,1'b1,8'hFF,4'h9,16'h002C,16'h8080,16'h0000};
    vecs[24] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h40A70000,16'h0030,
                 1'b0,1'b1,1'b0,1'b1,8'hFF,4'h9,16'h002C,16'h8080,16'h0000};
    vecs[25] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'h7,16'h0777,32'hA0010000,16'h0034,
                 1'b0,1'b0,1'b1,1'b1,8'hA0,4'h0,16'h0034,16'h1111,16'h0000};
    vecs[26] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01310200,16'h0038,
                 1'b0,1'b1,1'b0,1'b0,8'hFF,4'h0,16'h0000,16'h0000,16'h0000};
    vecs[27] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,32'h01310200,16'h0038,
                 1'b0,1'b0,1'b0,1'b1,8'h01,4'h3,16'h0038,16'h0000,16'h0000};
    vecs[28] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'h0,16'h0000,32'h40A90005,16'h003C,
                 1'b0,1'b0,1'b0,1'b1,8'h40,4'hA,16'h003C,16'h0000,16'h0005};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'hFF000000, 16'h0000);
    @(negedge I_CLOCK);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].lock, vecs[i].fst, vecs[i].frz, vecs[i].bas, vecs[i].wbe,
            vecs[i].wbi, vecs[i].wbd, vecs[i].ir, vecs[i].pc);
      #1;
      check($sformatf("v%0d dep_stall", i), 32'(O_DepStallSignal), 32'(vecs[i].e_dep));
      @(negedge I_CLOCK);
      #1;
      check($sformatf("v%0d de_stall", i), 32'(O_DEStall), 32'(vecs[i].e_destall));
      check($sformatf("v%0d opcode", i), 32'(O_Opcode), 32'(vecs[i].e_op));
      check($sformatf("v%0d dest", i), 32'(O_DestRegIdx), 32'(vecs[i].e_dr));
      check($sformatf("v%0d pc", i), 32'(O_PC), 32'(vecs[i].e_pc));
      check($sformatf("v%0d src1", i), 32'(O_Src1Value), 32'(vecs[i].e_s1));
      check($sformatf("v%0d src2", i), 32'(O_Src2Value), 32'(vecs[i].e_s2));
      check($sformatf("v%0d br_stall", i), 32'(O_BranchStallSignal), 32'(vecs[i].e_bs));
      check($sformatf("v%0d lock", i), 32'(O_LOCK), 32'(vecs[i].e_lock));
    end

    // Branch held pending across several edges, then resolved.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h80000000, 16'h0040);
    @(negedge I_CLOCK);
    #1;
    check("seq br issue opcode", 32'(O_Opcode), 32'h80);
    check("seq br issue pending", 32'(O_BranchStallSignal), 32'h1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h01B10200, 16'h0044);
      #1;
      check($sformatf("seq hold%0d dep", k), 32'(O_DepStallSignal), 32'h0);
      @(negedge I_CLOCK);
      #1;
      check($sformatf("seq hold%0d de_stall", k), 32'(O_DEStall), 32'h1);
      check($sformatf("seq hold%0d pending", k), 32'(O_BranchStallSignal), 32'h1);
    end
    I_BranchAddrSelect = 1'b1;
    @(negedge I_CLOCK);
    #1;
    check("seq resolve pending", 32'(O_BranchStallSignal), 32'h0);
    check("seq resolve de_stall", 32'(O_DEStall), 32'h1);
    I_BranchAddrSelect = 1'b0;
    @(negedge I_CLOCK);
    #1;
    check("seq after de_stall", 32'(O_DEStall), 32'h0);
    check("seq after opcode", 32'(O_Opcode), 32'h01);
    check("seq after dest", 32'(O_DestRegIdx), 32'hB);
    check("seq after pc", 32'(O_PC), 32'h0044);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- FE/DE consumer: takes the fetched instruction word from the fetch stage, decodes it and reads the register file.
- Tracks in-flight destination registers in a scoreboard and produces the dependency-stall and branch-stall signals that fetch obeys.
- Drives a registered DE/EX latch; invalid slots are marked as bubbles.

Parameters:
- DATA_WIDTH, 16, register and operand width.
- NUM_REGS, 16, architectural registers; index width is 4.
- SB_MAX, 3, maximum in-flight writers per register; uses a 2-bit counter.

Ports:
- I_CLOCK  in  1  stage clock; all state updates on the falling edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_LOCK  in  1  pipeline enable from the fetch stage's O_LOCK.
- I_PC  in  16  PC+4 of the fetched instruction.
- I_IR  in  32  fetched instruction.
- I_FetchStall  in  1  incoming slot is a bubble.
- I_FRAMESTALL  in  1  global freeze.
- I_BranchAddrSelect  in  1  branch target resolved this cycle.
- I_WBEnable  in  1  writeback valid.
- I_WBRegIdx  in  4  writeback register.
- I_WBData  in  DATA_WIDTH  writeback value.
- O_LOCK  out  1  registered I_LOCK.
- O_PC  out  16  latched PC.
- O_Opcode  out  8  latched opcode.
- O_DestRegIdx  out  4  latched destination register.
- O_Src1Value  out  DATA_WIDTH  operand 1.
- O_Src2Value  out  DATA_WIDTH  operand 2, or sign-extended imm16.
- O_DEStall  out  1  DE/EX slot is a bubble.
- O_DepStallSignal  out  1  combinational; hazard on the current I_IR.
- O_BranchStallSignal  out  1  registered; branch in flight.

Behaviour:
- Instruction fields: opcode IR[31:24], DR IR[23:20], SR1 IR[19:16], SR2 IR[11:8], imm16 IR[15:0].
- Instruction classes by opcode[7:6]:
  - 00: reg-reg ALU; reads SR1 and SR2, writes DR.
  - 01: reg-imm ALU; reads SR1, writes DR; O_Src2Value = sext(imm16).
  - 10: branch; reads SR1 only when opcode[5]=1; no write.
  - 11: store; reads SR1 and SR2, no write.
  - 8'hFF is NOP and matches no class.
- Reset, synchronous on a falling edge with I_RESET=1:
  - All outputs are 0, except O_Opcode=8'hFF and O_DEStall=1.
  - All scoreboard counters are 0 and the branch-pending flag is 0.
  - Register file is cleared to 0.
  - I_RESET has priority over every other input; asserting it mid-branch clears the pending branch.
- Writeback applies every edge when I_WBEnable=1, including during I_FRAMESTALL or I_LOCK=0.
  - The register file is written.
  - The scoreboard counter for I_WBRegIdx decrements; it never goes below 0.
- Read bypass: a source equal to I_WBRegIdx while I_WBEnable=1 reads I_WBData in the same cycle.
- Hazard, combinational: any source read by the current I_IR has an effective count (counter, minus 1 if written back this cycle) that is nonzero.
  - Also a hazard: the instruction writes DR and counter[DR] == SB_MAX.
- O_DepStallSignal = hazard AND I_LOCK AND NOT I_FetchStall AND NOT branch-pending.
- Issue condition: I_LOCK=1, I_FRAMESTALL=0, I_FetchStall=0, no hazard, branch-pending=0, opcode != 8'hFF.
  - On issue, latch the PC, opcode, DR and operands; O_DEStall=0.
  - If the instruction writes DR, counter[DR] increments. An increment and decrement on the same register in the same edge leaves it unchanged.
  - If the instruction is a branch, branch-pending is set to 1.
- Non-issue, not frozen: O_DEStall=1, O_Opcode=8'hFF, all other DE/EX fields hold their values, and the scoreboard is unchanged except for writeback. Latency is one edge.
- I_FRAMESTALL=1: the entire DE/EX latch and branch-pending hold; only writeback proceeds.
- O_BranchStallSignal = branch-pending.
  - It clears on the edge where I_BranchAddrSelect=1.
  - Instructions presented while pending, including in that same edge, are dropped as bubbles.
  - An I_BranchAddrSelect with no branch pending is ignored.
- I_LOCK=0: the stage emits bubbles and O_LOCK follows I_LOCK one edge later.

Test Plan:
- Reset: hold I_RESET for 2 edges -> O_DEStall=1, O_Opcode=FF, O_BranchStallSignal=0, all counters 0.
- Issue write r3, then present a reader of r3 -> O_DepStallSignal=1 and bubbles while counter[r3]=1. With I_WBEnable=1, I_WBRegIdx=3, I_WBData=16'h00AB -> issues that edge with Src1=00AB, no stall.
- Issue 3 writers to r5 with no writeback -> counter=3. A 4th writer of r5 raises O_DepStallSignal. Simultaneous issue and writeback on r5 leaves the counter at its value.
- Issue a branch (opcode 8'h80) -> O_BranchStallSignal=1 next edge, and the following instructions become bubbles. Pulse I_BranchAddrSelect -> signal 0 after that edge, and the next instruction issues.
- Assert I_FRAMESTALL for 3 edges during a writeback -> the DE/EX outputs are unchanged and the register file shows the written value afterwards.
- With a branch pending, assert I_RESET -> O_BranchStallSignal=0 and the scoreboard is cleared on that edge.
